freq_gate_ctrl: RTL

Gate-time sequencer and auto-ranging controller for the frequency meter counter datapath. On a start request (or continuously) it clears the counter, opens a counting gate of programmable length, locks the result, then checks the count. If the count overflowed or is below a low threshold, it steps the gate range and re-measures; otherwise it reports completion. It sits between the system control logic and the counter/lock datapath, and drives the datapath's clear, enable and lock strobes.

---
 rtl/freq_meter_pkg.sv | 39 +++
 rtl/freq_gate_ctrl_gate_timer.sv | 33 +++
 rtl/freq_gate_ctrl.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/freq_meter_pkg.sv
// Shared encodings for the frequency meter gate controller: FSM states,
// range width and the bit layout of the datapath strobe vector.
package freq_meter_pkg;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_CLR  = 3'd1;
    localparam logic [2:0] ST_GATE = 3'd2;
    localparam logic [2:0] ST_LOCK = 3'd3;
    localparam logic [2:0] ST_EVAL = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE = ST_IDLE,
        S_CLR  = ST_CLR,
        S_GATE = ST_GATE,
        S_LOCK = ST_LOCK,
        S_EVAL = ST_EVAL
    } state_e;

    localparam int RANGE_W = 2;

    localparam int STB_CLEAR = 0;
    localparam int STB_COUNT = 1;
    localparam int STB_LOCK  = 2;
    localparam int STB_W     = 3;

    // At most one strobe is ever set, so the datapath never sees clear and enable together.
    function automatic logic [STB_W-1:0] strobes_for(input state_e st);
        logic [STB_W-1:0] s;
        s = {STB_W{1'b0}};
        case (st)
            S_CLR:   s[STB_CLEAR] = 1'b1;
            S_GATE:  s[STB_COUNT] = 1'b1;
            S_LOCK:  s[STB_LOCK]  = 1'b1;
            default: s = {STB_W{1'b0}};
        endcase
        return s;
    endfunction

endpackage

// File: rtl/freq_gate_ctrl_gate_timer.sv
// Loadable down-counter that times the counting gate; zero marks the last gate cycle.
module gate_timer #(
    parameter int GATE_W = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              en,
    input  logic [GATE_W-1:0] load_val,
    output logic              zero
);

    localparam logic [GATE_W-1:0] ZERO = {GATE_W{1'b0}};
    localparam logic [GATE_W-1:0] ONE  = {{(GATE_W-1){1'b0}}, 1'b1};

    logic [GATE_W-1:0] count_r;

    // Load wins over decrement; the counter parks at zero rather than wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= ZERO;
        end else if (load) begin
            count_r <= load_val;
        end else if (en && (count_r != ZERO)) begin
            count_r <= count_r - ONE;
        end else begin
            count_r <= count_r;
        end
    end

    assign zero = (count_r == ZERO);

endmodule

// File: rtl/freq_gate_ctrl.sv
// Gate-time sequencer and auto-ranging controller: clears, gates and locks the
// counter datapath, then steps the gate range on overflow or a low count.
module freq_gate_ctrl
    import freq_meter_pkg::*;
#(
    parameter int CNT_W     = 32,
    parameter int GATE_W    = 24,
    parameter int GATE_BASE = 1000,
    parameter int RANGE_MAX = 3,
    parameter int LOW_TH    = 1000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic               cont_i,
    input  logic [CNT_W-1:0]   cnt_val_i,
    input  logic               cnt_ovf_i,
    output logic               clear_o,
    output logic               count_en_o,
    output logic               lock_o,
    output logic [RANGE_W-1:0] range_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               ovf_err_o
);

    localparam logic [GATE_W-1:0]  BASE_LEN   = GATE_W'(GATE_BASE);
    localparam logic [GATE_W-1:0]  GATE_ONE   = {{(GATE_W-1){1'b0}}, 1'b1};
    localparam logic [RANGE_W-1:0] RANGE_TOP  = RANGE_W'(RANGE_MAX);
    localparam logic [RANGE_W-1:0] RANGE_ZERO = {RANGE_W{1'b0}};
    localparam logic [RANGE_W-1:0] RANGE_ONE  = {{(RANGE_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]   LOW_LEVEL  = CNT_W'(LOW_TH);

    state_e             state_r;
    state_e             next_state_s;
    logic [RANGE_W-1:0] range_r;
    logic [RANGE_W-1:0] range_next_s;
    logic [RANGE_W-1:0] retry_r;
    logic [RANGE_W-1:0] retry_next_s;
    logic               ovf_seen_r;
    logic               finish_s;
    logic               retry_left_s;
    logic               timer_load_s;
    logic               timer_en_s;
    logic               timer_zero_s;
    logic [GATE_W-1:0]  gate_load_s;
    logic [STB_W-1:0]   strobe_r;

    assign gate_load_s  = (BASE_LEN << range_r) - GATE_ONE;
    assign retry_left_s = (retry_r < RANGE_TOP);
    assign timer_load_s = (state_r == S_CLR);
    assign timer_en_s   = (state_r == S_GATE);

    gate_timer #(
        .GATE_W(GATE_W)
    ) u_gate_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (timer_load_s),
        .en       (timer_en_s),
        .load_val (gate_load_s),
        .zero     (timer_zero_s)
    );

    // Next-state and ranging decision; retries bound up/down oscillation between ranges.
    always_comb begin
        next_state_s = state_r;
        range_next_s = range_r;
        retry_next_s = retry_r;
        finish_s     = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (start_i || cont_i) begin
                    next_state_s = S_CLR;
                end else begin
                    next_state_s = S_IDLE;
                end
            end
            S_CLR: next_state_s = S_GATE;
            S_GATE: begin
                if (timer_zero_s || cnt_ovf_i) begin
                    next_state_s = S_LOCK;
                end else begin
                    next_state_s = S_GATE;
                end
            end
            S_LOCK: next_state_s = S_EVAL;
            S_EVAL: begin
                if (ovf_seen_r && (range_r != RANGE_ZERO) && retry_left_s) begin
                    range_next_s = range_r - RANGE_ONE;
                    retry_next_s = retry_r + RANGE_ONE;
                    next_state_s = S_CLR;
                end else if (!ovf_seen_r && (cnt_val_i < LOW_LEVEL) &&
                             (range_r < RANGE_TOP) && retry_left_s) begin
                    range_next_s = range_r + RANGE_ONE;
                    retry_next_s = retry_r + RANGE_ONE;
                    next_state_s = S_CLR;
                end else begin
                    finish_s     = 1'b1;
                    retry_next_s = RANGE_ZERO;
                    if (cont_i) begin
                        next_state_s = S_CLR;
                    end else begin
                        next_state_s = S_IDLE;
                    end
                end
            end
            default: next_state_s = S_IDLE;
        endcase
    end

    // State, ranging registers and outputs; outputs are decoded from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= S_IDLE;
            range_r    <= RANGE_ZERO;
            retry_r    <= RANGE_ZERO;
            ovf_seen_r <= 1'b0;
            strobe_r   <= {STB_W{1'b0}};
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            ovf_err_o  <= 1'b0;
        end else begin
            state_r  <= next_state_s;
            range_r  <= range_next_s;
            retry_r  <= retry_next_s;
            strobe_r <= strobes_for(next_state_s);
            busy_o   <= (next_state_s != S_IDLE);
            done_o   <= finish_s;
            if (state_r == S_CLR) begin
                ovf_seen_r <= 1'b0;
            end else if (((state_r == S_GATE) || (state_r == S_LOCK)) && cnt_ovf_i) begin
                ovf_seen_r <= 1'b1;
            end else begin
                ovf_seen_r <= ovf_seen_r;
            end
            if (finish_s) begin
                ovf_err_o <= ovf_seen_r;
            end else begin
                ovf_err_o <= ovf_err_o;
            end
        end
    end

    assign clear_o    = strobe_r[STB_CLEAR];
    assign count_en_o = strobe_r[STB_COUNT];
    assign lock_o     = strobe_r[STB_LOCK];
    assign range_o    = range_r;

endmodule
